// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: grants the shared water supply to sprinkler or drip with min/max on-time and cooldown.
// Define ROUND_ROBIN_EN to alternate tied requests; otherwise the sprinkler wins every tie.
module irrigation_scheduler #(
   parameter int CNT_W  = 8,
   parameter int MIN_ON = 5,
   parameter int MAX_ON = 60,
   parameter int COOL   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             req_as,
   input  logic             req_gt,
   input  logic             alin,
   output logic             va,
   output logic             vg,
   output logic             busy,
   output logic             timeout,
   output logic             fault,
   output logic [CNT_W-1:0] sec
);
   typedef enum logic [2:0] {IDLE, RUN_AS, RUN_GT, COOLDOWN, FAULT} stateT;
   localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_ON);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ON);
   localparam logic [CNT_W-1:0] COOL_C = CNT_W'(COOL);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   stateT state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext, cntInc;
   logic timeoutNext, runReq, tieAs;
`ifdef ROUND_ROBIN_EN
   logic lastAs;
   assign tieAs = !lastAs;
   always_ff @(posedge clk)
      if (!rst_n) lastAs <= 1'b0;
      else if (state == IDLE && !alin && (req_as || req_gt)) lastAs <= (stateNext == RUN_AS);
`else
   assign tieAs = 1'b1;
`endif
   always_comb begin
      stateNext   = state;
      cntNext     = cnt;
      timeoutNext = timeout;
      runReq      = (state == RUN_AS) ? req_as : req_gt;
      // increment is applied before the MIN_ON compare
      cntInc      = (tick && cnt < MAX_C) ? cnt + ONE : cnt;
      if (alin) begin
         stateNext = FAULT;
         cntNext   = '0;
      end else begin
         case (state)
            IDLE:
               if (req_as || req_gt) begin
                  stateNext   = (req_as && (!req_gt || tieAs)) ? RUN_AS : RUN_GT;
                  cntNext     = '0;
                  timeoutNext = 1'b0;
               end
            RUN_AS, RUN_GT:
               if (cnt == MAX_C) begin
                  stateNext   = COOLDOWN;
                  cntNext     = '0;
                  timeoutNext = 1'b1;
               end else if (!runReq && cntInc >= MIN_C) begin
                  stateNext = COOLDOWN;
                  cntNext   = '0;
               end else cntNext = cntInc;
            COOLDOWN: begin
               stateNext = (cnt == COOL_C) ? IDLE : COOLDOWN;
               cntNext   = (tick && cnt != COOL_C) ? cnt + ONE : cnt;
            end
            FAULT: begin
               stateNext = COOLDOWN;
               cntNext   = '0;
            end
            default: stateNext = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         state   <= stateNext;
         cnt     <= cntNext;
         timeout <= timeoutNext;
      end
   assign va    = (state == RUN_AS);
   assign vg    = (state == RUN_GT);
   assign busy  = va || vg || (state == COOLDOWN);
   assign fault = (state == FAULT);
   assign sec   = (va || vg) ? cnt : '0;
endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb_irrigation_scheduler: scoreboard bench for irrigation_scheduler (MIN_ON=5, MAX_ON=60, COOL=3).
module tb_irrigation_scheduler;
   logic clk = 0, rst_n = 0, tick = 0, req_as = 0, req_gt = 0, alin = 0;
   logic va, vg, busy, timeout, fault;
   logic [7:0] sec;
   int errors = 0, checks = 0;
   typedef struct {string tag; logic [12:0] exp;} expT;
   expT sb[$];
   localparam logic [4:0] OFF = 5'b00000, AS = 5'b10100, GT = 5'b01100, CL = 5'b00100, TO = 5'b00010, FL = 5'b00001;

   irrigation_scheduler #(.CNT_W(8), .MIN_ON(5), .MAX_ON(60), .COOL(3)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .req_as(req_as), .req_gt(req_gt), .alin(alin),
      .va(va), .vg(vg), .busy(busy), .timeout(timeout), .fault(fault), .sec(sec));

   always #5 clk = ~clk;

   assert property (@(posedge clk) disable iff (!rst_n) !(va && vg)) else $error("FAIL va and vg both high");

   task automatic checkVal(string tag, logic [12:0] obs, logic [12:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got {va,vg,busy,to,fault,sec}=%b_%h expected %b_%h", tag, obs[12:8], obs[7:0], exp[12:8], exp[7:0]);
      end
   endtask

   // expected output pushed with the stimulus, popped when the DUT outputs are sampled
   task automatic see(string tag, logic [4:0] flags, int s);
      expT e;
      sb.push_back('{tag, {flags, 8'(s)}});
      e = sb.pop_front();
      checkVal(e.tag, {va, vg, busy, timeout, fault, sec}, e.exp);
   endtask

   task automatic clkCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic tickOnce();
      clkCycle();
      tick = 1;
      clkCycle();
      tick = 0;
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tickOnce();
   endtask

   task automatic finishCool(logic [4:0] coolFlags, logic [4:0] idleFlags);
      for (int i = 0; i < 3; i++) begin
         tickOnce();
         see("coolTick", coolFlags, 0);
      end
      clkCycle();
      see("coolIdle", idleFlags, 0);
   endtask

   initial begin
      req_as = 1;
      clkCycle();
      clkCycle();
      see("reset", OFF, 0);
      rst_n = 1;
      clkCycle();
      see("rstRelease", AS, 0);
      ticks(2);
      see("minHeld", AS, 2);
      req_as = 0;
      ticks(2);
      see("minHold4", AS, 4);
      tickOnce();
      see("minEnd", CL, 0);
      finishCool(CL, OFF);

      req_gt = 1;
      clkCycle();
      see("gtGrant", GT, 0);
      for (int i = 1; i <= 60; i++) begin
         tickOnce();
         see("gtSec", GT, i);
      end
      clkCycle();
      see("timeout", CL | TO, 0);
      finishCool(CL | TO, TO);
      clkCycle();
      see("gtRegrant", GT, 0);
      req_gt = 0;
      ticks(5);
      see("gtRelease", CL, 0);
      finishCool(CL, OFF);

      req_as = 1;
      clkCycle();
      see("alarmRun", AS, 0);
      ticks(20);
      see("alarmSec20", AS, 20);
      alin = 1;
      clkCycle();
      see("faultEnter", FL, 0);
      tickOnce();
      see("faultHold", FL, 0);
      alin = 0;
      clkCycle();
      see("faultCool", CL, 0);
      finishCool(CL, OFF);
      clkCycle();
      see("alarmRegrant", AS, 0);
      req_as = 0;
      ticks(5);
      see("alarmRelease", CL, 0);
      finishCool(CL, OFF);

      rst_n = 0;
      clkCycle();
      rst_n = 1;
      clkCycle();
      see("tieIdle", OFF, 0);
      for (int k = 0; k < 3; k++) begin
         req_as = 1;
         req_gt = 1;
         clkCycle();
`ifdef ROUND_ROBIN_EN
         see("tieGrant", (k % 2 == 0) ? AS : GT, 0);
`else
         see("tieGrant", AS, 0);
`endif
         req_as = 0;
         req_gt = 0;
         ticks(5);
         see("tieRelease", CL, 0);
         finishCool(CL, OFF);
      end

      req_as = 1;
      clkCycle();
      see("maskRun", AS, 0);
      req_as = 0;
      ticks(5);
      see("maskCool", CL, 0);
      req_gt = 1;
      finishCool(CL, OFF);
      clkCycle();
      see("maskGrant", GT, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
